// File: rtl/byte_store_arbiter.sv
// byte_store_arbiter
//   Two-requester round-robin arbiter in front of a 4x8 latch store.
//   Each accepted access walks SETUP -> (STROBE x STROBE_CYCLES -> HOLD | READ)
//   -> DONE, so slot select and data are settled before the latch enable
//   rises and stay settled until after it falls.
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   a_/b_req,we,addr,wdata   : requester A/B access request
//   a_/b_gnt                 : one-cycle accept pulse
//   a_/b_done                : one-cycle completion pulse
//   rdata                    : last read result, held between reads
//   mem_sel, mem_din, mem_en : slot select, data, latch-enable to the store
//   mem_dout                 : muxed store output
module byte_store_arbiter #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_we,
  input  logic       b_we,
  input  logic [1:0] a_addr,
  input  logic [1:0] b_addr,
  input  logic [7:0] a_wdata,
  input  logic [7:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       a_done,
  output logic       b_done,
  output logic [7:0] rdata,
  output logic [1:0] mem_sel,
  output logic [7:0] mem_din,
  output logic       mem_en,
  input  logic [7:0] mem_dout
);

  localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ, DONE} state_t;

  state_t     r_state;
  logic       r_we;
  logic       r_win_b;   // current owner: 1 = B
  logic       r_last_b;  // previous winner: 1 = B
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic [7:0] r_din;
  logic       r_en;
  logic [7:0] r_rdata;
  logic       r_a_gnt, r_b_gnt, r_a_done, r_b_done;

  // B wins when alone, or when both ask and A was served last.
  logic w_pick_b;
  assign w_pick_b = b_req & (~a_req | ~r_last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_win_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_cnt    <= 4'd0;
      r_sel    <= 2'd0;
      r_din    <= 8'd0;
      r_en     <= 1'b0;
      r_rdata  <= 8'd0;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
    end else begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (a_req | b_req) begin
            r_win_b <= w_pick_b;
            r_we    <= w_pick_b ? b_we    : a_we;
            // sel/din only ever move here, never while the latch is open
            r_sel   <= w_pick_b ? b_addr  : a_addr;
            r_din   <= w_pick_b ? b_wdata : a_wdata;
            r_a_gnt <= ~w_pick_b;
            r_b_gnt <= w_pick_b;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_we) begin
            r_en    <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= STROBE;
          end else begin
            r_state <= READ;
          end
        end
        STROBE: begin
          if (r_cnt == LAST_CNT) begin
            r_en    <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HOLD: r_state <= DONE;
        READ: begin
          r_rdata <= mem_dout;
          r_state <= DONE;
        end
        DONE: begin
          r_a_done <= ~r_win_b;
          r_b_done <= r_win_b;
          r_last_b <= r_win_b;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_gnt   = r_a_gnt;
  assign b_gnt   = r_b_gnt;
  assign a_done  = r_a_done;
  assign b_done  = r_b_done;
  assign rdata   = r_rdata;
  assign mem_sel = r_sel;
  assign mem_din = r_din;
  assign mem_en  = r_en;

endmodule

// File: tb/tb_byte_store_arbiter.sv
// Directed bench for byte_store_arbiter: one instance with the default
// strobe length and one with STROBE_CYCLES=3, each with its own 4x8 store.
module tb_byte_store_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [1:0] a_addr = 2'd0, b_addr = 2'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;

  logic       a_gnt, b_gnt, a_done, b_done, mem_en;
  logic [7:0] rdata, mem_din, mem_dout;
  logic [1:0] mem_sel;
  logic       a_gnt3, b_gnt3, a_done3, b_done3, mem_en3;
  logic [7:0] rdata3, mem_din3, mem_dout3;
  logic [1:0] mem_sel3;

  logic [7:0] store1 [4];
  logic [7:0] store3 [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_store_arbiter #(.STROBE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done), .rdata(rdata),
    .mem_sel(mem_sel), .mem_din(mem_din), .mem_en(mem_en), .mem_dout(mem_dout));

  byte_store_arbiter #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt3), .b_gnt(b_gnt3), .a_done(a_done3), .b_done(b_done3), .rdata(rdata3),
    .mem_sel(mem_sel3), .mem_din(mem_din3), .mem_en(mem_en3), .mem_dout(mem_dout3));

  // Store model: the selected byte takes mem_din while the enable is high.
  initial for (int i = 0; i < 4; i++) begin store1[i] = 8'h00; store3[i] = 8'h00; end
  always @(posedge clk) if (mem_en)  store1[mem_sel]  <= mem_din;
  always @(posedge clk) if (mem_en3) store3[mem_sel3] <= mem_din3;
  assign mem_dout  = store1[mem_sel];
  assign mem_dout3 = store3[mem_sel3];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one access from a single requester and measures it on the chosen
  // instance; returns at the negedge where done is seen.
  task automatic run_access(input bit use3, input bit side_b, input bit we,
                            input logic [1:0] addr, input logic [7:0] wd,
                            output int gnt_wait, output int lat, output int en_cnt,
                            output bit stable, output bit other, output bit tmo);
    int t0, g;
    bit got_g, gn, dn, en, og;
    logic [1:0] sel;
    logic [7:0] din;
    if (side_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else        begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    t0 = cyc; g = 0; got_g = 0; en_cnt = 0; stable = 1; other = 0; tmo = 1;
    gnt_wait = -1; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gn  = use3 ? (side_b ? b_gnt3  : a_gnt3)  : (side_b ? b_gnt  : a_gnt);
      dn  = use3 ? (side_b ? b_done3 : a_done3) : (side_b ? b_done : a_done);
      og  = use3 ? (side_b ? (a_gnt3 | a_done3) : (b_gnt3 | b_done3))
                 : (side_b ? (a_gnt | a_done) : (b_gnt | b_done));
      en  = use3 ? mem_en3  : mem_en;
      sel = use3 ? mem_sel3 : mem_sel;
      din = use3 ? mem_din3 : mem_din;
      if (!got_g && gn) begin
        got_g = 1; g = cyc; gnt_wait = cyc - t0;
        a_req = 1'b0; b_req = 1'b0;
      end
      if (got_g) begin
        if (en) en_cnt++;
        if (sel !== addr || din !== wd) stable = 0;
        if (og) other = 1;
        if (dn) begin lat = cyc - g; tmo = 0; break; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset();
    // request held high during reset must not be granted
    rst = 1'b1; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_priority gnt got a=%b b=%b want 0 0", a_gnt, b_gnt);
    end
    checks++;
    if ({mem_en, mem_sel, mem_din, rdata} !== 19'd0) begin
      failures++; $display("FAIL reset_mem got en=%b sel=%0d din=%h rdata=%h want all 0",
                           mem_en, mem_sel, mem_din, rdata);
    end
    checks++;
    if ({a_done, b_done, a_done3, b_done3, mem_en3} !== 5'd0) begin
      failures++; $display("FAIL reset_done got %b want 00000",
                           {a_done, b_done, a_done3, b_done3, mem_en3});
    end
    a_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int gw, lat, en_c; bit st, oth, tmo;
    do_reset();
    run_access(0, 0, 1, 2'd2, 8'hA5, gw, lat, en_c, st, oth, tmo);
    checks++;
    if (tmo || gw !== 1 || lat !== 4) begin
      failures++; $display("FAIL wr_timing got tmo=%b gnt_wait=%0d lat=%0d want 0 1 4", tmo, gw, lat);
    end
    checks++;
    if (en_c !== 1 || !st || oth) begin
      failures++; $display("FAIL wr_strobe got en_cycles=%0d stable=%b other=%b want 1 1 0", en_c, st, oth);
    end
    checks++;
    if (rdata !== 8'h00) begin
      failures++; $display("FAIL wr_rdata_kept got %h want 00", rdata);
    end
    run_access(0, 0, 0, 2'd2, 8'h00, gw, lat, en_c, st, oth, tmo);
    checks++;
    if (tmo || lat !== 3 || en_c !== 0) begin
      failures++; $display("FAIL rd_timing got tmo=%b lat=%0d en_cycles=%0d want 0 3 0", tmo, lat, en_c);
    end
    checks++;
    if (rdata !== 8'hA5) begin
      failures++; $display("FAIL rd_data got %h want a5", rdata);
    end
  endtask

  task automatic test_contention();
    bit order [3];
    int n = 0;
    bit overlap = 0;
    do_reset();
    a_we = 1'b0; b_we = 1'b0; a_addr = 2'd0; b_addr = 2'd1;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (a_gnt && b_gnt) overlap = 1;
      if (a_gnt || b_gnt) begin
        order[n] = b_gnt; n++;
        if (n == 3) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_gnt && b_gnt) overlap = 1;
    end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL cont_count got %0d grants want 3", n);
    end else begin
      checks++;
      if (order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0) begin
        failures++; $display("FAIL cont_order got b-flags %b%b%b want 010", order[0], order[1], order[2]);
      end
    end
    checks++;
    if (overlap) begin
      failures++; $display("FAIL cont_overlap got overlap=1 want 0");
    end
  endtask

  task automatic test_strobe3();
    int gw, lat, en_c; bit st, oth, tmo;
    do_reset();
    run_access(1, 1, 1, 2'd3, 8'h3C, gw, lat, en_c, st, oth, tmo);
    checks++;
    if (tmo || gw !== 1 || lat !== 6) begin
      failures++; $display("FAIL s3_timing got tmo=%b gnt_wait=%0d lat=%0d want 0 1 6", tmo, gw, lat);
    end
    checks++;
    if (en_c !== 3 || !st || oth) begin
      failures++; $display("FAIL s3_strobe got en_cycles=%0d stable=%b other=%b want 3 1 0", en_c, st, oth);
    end
    run_access(1, 1, 0, 2'd3, 8'h00, gw, lat, en_c, st, oth, tmo);
    checks++;
    if (tmo || lat !== 3 || rdata3 !== 8'h3C) begin
      failures++; $display("FAIL s3_readback got tmo=%b lat=%0d rdata=%h want 0 3 3c", tmo, lat, rdata3);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_en = 0;
    bit bad = 0;
    int g = 0;
    int lat = -1;
    do_reset();
    a_we = 1'b1; a_addr = 2'd1; a_wdata = 8'h77; a_req = 1'b1;
    for (int i = 0; i < 10 && !seen_en; i++) begin
      @(negedge clk);
      if (a_gnt) a_req = 1'b0;
      if (mem_en) seen_en = 1;
    end
    a_req = 1'b0;
    checks++;
    if (!seen_en) begin
      failures++; $display("FAIL rmid_strobe got no mem_en want strobe");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem_en !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL rmid_abort got en=%b done=%b want 0 0", mem_en, a_done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_done || b_done || mem_en || a_gnt || b_gnt) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL rmid_quiet got activity after reset want none");
    end
    // both ask after reset: A must win
    a_we = 1'b0; b_we = 1'b0; a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      failures++; $display("FAIL rmid_winner got a=%b b=%b want 1 0", a_gnt, b_gnt);
    end
    a_req = 1'b0; b_req = 1'b0;
    g = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_done) begin lat = cyc - g; break; end
    end
    checks++;
    if (lat !== 3) begin
      failures++; $display("FAIL rmid_serve got lat=%0d want 3", lat);
    end
  endtask

  task automatic test_slots();
    logic [7:0] vals [4];
    int gw, lat, en_c; bit st, oth, tmo;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h44; vals[3] = 8'h88;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_access(0, 0, 1, 2'(i), vals[i], gw, lat, en_c, st, oth, tmo);
      checks++;
      if (tmo || lat !== 4 || rdata !== 8'h00) begin
        failures++; $display("FAIL slot_wr%0d got tmo=%b lat=%0d rdata=%h want 0 4 00", i, tmo, lat, rdata);
      end
    end
    for (int i = 0; i < 4; i++) begin
      run_access(0, 0, 0, 2'(i), 8'h00, gw, lat, en_c, st, oth, tmo);
      checks++;
      if (tmo || lat !== 3 || rdata !== vals[i]) begin
        failures++; $display("FAIL slot_rd%0d got tmo=%b lat=%0d rdata=%h want 0 3 %h", i, tmo, lat, rdata, vals[i]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rdata !== vals[i]) begin
        failures++; $display("FAIL slot_hold%0d got %h want %h", i, rdata, vals[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_strobe3();
    test_reset_mid();
    test_slots();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_store_arbiter.md
BYTE_STORE_ARBITER -- requirements
Module: byte_store_arbiter

Interface
REQ-001 The parameter STROBE_CYCLES SHALL default to 1 and SHALL set the mem_en high time in clock cycles (legal range 1..15).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single system clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-004 Ports a_req and b_req SHALL be inputs, 1 bit each: the access requests from requester A and requester B.
REQ-005 Ports a_we and b_we SHALL be inputs, 1 bit each: 1 requests a write, 0 requests a read.
REQ-006 Ports a_addr and b_addr SHALL be inputs, 2 bits each: the byte slot select, 0..3.
REQ-007 Ports a_wdata and b_wdata SHALL be inputs, 8 bits each: the write data.
REQ-008 Ports a_gnt and b_gnt SHALL be outputs, 1 bit each: high for exactly one cycle when the request is accepted.
REQ-009 Ports a_done and b_done SHALL be outputs, 1 bit each: high for exactly one cycle when the access completes.
REQ-010 Port rdata SHALL be an output, 8 bits wide: the read result, valid in the cycle the done output is high and held until the next read completes.
REQ-011 Port mem_sel SHALL be an output, 2 bits wide: drives the slot select of the 4x8 latch store's demux/mux.
REQ-012 Port mem_din SHALL be an output, 8 bits wide: the byte presented to the latch store.
REQ-013 Port mem_en SHALL be an output, 1 bit wide: the latch-enable strobe into the store's enable demux.
REQ-014 Port mem_dout SHALL be an input, 8 bits wide: the muxed output of the latch store.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD, READ and DONE.
REQ-016 In IDLE with any request pending, the block SHALL select a winner, register its we/addr/wdata, pulse the winner's gnt and go to SETUP on the next cycle.
REQ-017 Arbitration SHALL be round-robin: a last-winner flag SHALL reset to B, so A wins first. With both requests high, the requester that did not win last SHALL win. A lone requester SHALL win regardless of the flag.
REQ-018 SETUP SHALL last 1 cycle with mem_sel and mem_din driven from the registered request and mem_en=0. It SHALL then go to STROBE for a write or READ for a read.
REQ-019 STROBE SHALL hold mem_en=1 for exactly STROBE_CYCLES cycles using a 4-bit counter, then go to HOLD.
REQ-020 HOLD SHALL last 1 cycle with mem_en=0 and mem_sel/mem_din unchanged, which guarantees latch setup and hold margin; it SHALL then go to DONE.
REQ-021 READ SHALL last 1 cycle, capture mem_dout into rdata at its end, and go to DONE.
REQ-022 DONE SHALL last 1 cycle, pulse the winner's done output and update the last-winner flag, then go to IDLE.
REQ-023 Latency from gnt to done SHALL be STROBE_CYCLES+3 cycles for a write and 3 cycles for a read.
REQ-024 mem_sel and mem_din SHALL change only on the IDLE->SETUP transition, so they are never changed while mem_en is high.
REQ-025 Request inputs SHALL be ignored outside IDLE. A requester SHALL keep req high until gnt; dropping req before gnt withdraws the request.
REQ-026 A write SHALL leave rdata unchanged.
REQ-027 mem_en SHALL be a registered output, free of glitches, and high only in STROBE.

Reset
REQ-028 On rst high at a clock edge, the block SHALL enter IDLE regardless of state, including mid-strobe.
REQ-029 Reset values SHALL be: mem_en=0, mem_sel=0, mem_din=0, rdata=0, all gnt/done=0, counter=0, last-winner flag=B.
REQ-030 A transfer interrupted by reset SHALL produce no done pulse, and the targeted byte's content is undefined.
REQ-031 rst SHALL take priority over all requests in the same cycle.

Verification
REQ-032 Write check: after reset, A writes addr 2, data 0xA5 -> a_gnt in cycle 1, mem_sel=2 with mem_en high for 1 cycle, a_done 4 cycles after gnt; a following A read of addr 2 -> rdata=0xA5 with a_done 3 cycles after gnt.
REQ-033 Contention check: a_req and b_req high together for three accesses -> grants in order A, B, A; no gnt pulses overlap.
REQ-034 Strobe-length check: STROBE_CYCLES=3, B writes addr 3, data 0x3C -> mem_en high for exactly 3 cycles; mem_sel/mem_din stable from SETUP through HOLD; b_done 6 cycles after gnt.
REQ-035 Reset-during-operation check: rst asserted during STROBE -> mem_en=0 on the next edge, FSM in IDLE, no done pulse; a subsequent request is served normally with A winning.
REQ-036 Slot-isolation check: write all four slots with 0x11, 0x22, 0x44, 0x88, then read each back -> each value is returned unchanged and rdata holds between reads.
